// File: rtl/bus_request_arbiter_pkg.sv
// Shared types for the two-master round-robin bus arbiter.
package bus_request_arbiter_pkg;

    // Arbiter FSM: wait for a request, hold the slave transaction, wait for owner release.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Identifies one of the two masters.
    typedef logic master_id_t;

    localparam master_id_t MASTER0 = 1'b0;
    localparam master_id_t MASTER1 = 1'b1;

    localparam int ADDR_W = 32;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
module rr_pick2
    import bus_request_arbiter_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  master_id_t i_last_grant,
    output logic       o_grant_valid,
    output master_id_t o_grant_id
);

    // On contention the master that did not win last time goes next.
    always_comb begin
        o_grant_valid = i_req0 | i_req1;
        o_grant_id    = MASTER0;
        if (i_req0 && i_req1) begin
            o_grant_id = ~i_last_grant;
        end else if (i_req1) begin
            o_grant_id = MASTER1;
        end
    end

endmodule

// File: rtl/bus_request_arbiter.sv
// Two-master round-robin arbiter in front of one held-request slave port.
// The winner's payload is latched and held on o_s_* until the slave
// completes; the completion is then returned to the owner with the same
// held-request/ready handshake the slave uses.
module bus_request_arbiter
    import bus_request_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              i_clock,
    input  logic              i_reset_n,

    input  logic              i_m0_request,
    input  logic              i_m0_rw,
    input  logic [ADDR_W-1:0] i_m0_address,
    input  logic [WIDTH-1:0]  i_m0_wdata,
    output logic [WIDTH-1:0]  o_m0_rdata,
    output logic              o_m0_ready,

    input  logic              i_m1_request,
    input  logic              i_m1_rw,
    input  logic [ADDR_W-1:0] i_m1_address,
    input  logic [WIDTH-1:0]  i_m1_wdata,
    output logic [WIDTH-1:0]  o_m1_rdata,
    output logic              o_m1_ready,

    output logic              o_s_request,
    output logic              o_s_rw,
    output logic [ADDR_W-1:0] o_s_address,
    output logic [WIDTH-1:0]  o_s_wdata,
    input  logic [WIDTH-1:0]  i_s_rdata,
    input  logic              i_s_ready
);

    // Registered state
    state_t                  r_state;
    master_id_t              r_owner;
    master_id_t              r_last_grant;
    logic                    r_s_request;
    logic                    r_s_rw;
    logic [ADDR_W-1:0]       r_s_address;
    logic [WIDTH-1:0]        r_s_wdata;
    logic [1:0][WIDTH-1:0]   r_m_rdata;
    logic [1:0]              r_m_ready;

    // Next-state values
    state_t                  w_state_next;
    master_id_t              w_owner_next;
    master_id_t              w_last_grant_next;
    logic                    w_s_request_next;
    logic                    w_s_rw_next;
    logic [ADDR_W-1:0]       w_s_address_next;
    logic [WIDTH-1:0]        w_s_wdata_next;
    logic [1:0][WIDTH-1:0]   w_m_rdata_next;
    logic [1:0]              w_m_ready_next;

    // Per-master request view and picker result
    logic [1:0]              w_req;
    logic                    w_owner_req;
    logic                    w_grant_valid;
    master_id_t              w_grant_id;
    logic                    w_sel_rw;
    logic [ADDR_W-1:0]       w_sel_address;
    logic [WIDTH-1:0]        w_sel_wdata;

    assign w_req       = {i_m1_request, i_m0_request};
    assign w_owner_req = w_req[r_owner];

    rr_pick2 u_pick (
        .i_req0        (i_m0_request),
        .i_req1        (i_m1_request),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Payload of whichever master the picker selects this cycle.
    always_comb begin
        w_sel_rw      = i_m0_rw;
        w_sel_address = i_m0_address;
        w_sel_wdata   = i_m0_wdata;
        if (w_grant_id == MASTER1) begin
            w_sel_rw      = i_m1_rw;
            w_sel_address = i_m1_address;
            w_sel_wdata   = i_m1_wdata;
        end
    end

    // Next-state and next-output logic; everything holds unless a case below moves it.
    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_grant_next = r_last_grant;
        w_s_request_next  = r_s_request;
        w_s_rw_next       = r_s_rw;
        w_s_address_next  = r_s_address;
        w_s_wdata_next    = r_s_wdata;
        w_m_rdata_next    = r_m_rdata;
        w_m_ready_next    = r_m_ready;

        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_owner_next      = w_grant_id;
                    w_last_grant_next = w_grant_id;
                    w_s_request_next  = 1'b1;
                    w_s_rw_next       = w_sel_rw;
                    w_s_address_next  = w_sel_address;
                    w_s_wdata_next    = w_sel_wdata;
                    w_state_next      = BUSY;
                end
            end

            BUSY: begin
                // o_s_* stay frozen until the slave completes. An owner that
                // already dropped its request gets no ready, so RELEASE will
                // fall straight through.
                if (i_s_ready) begin
                    if (!r_s_rw) begin
                        w_m_rdata_next[r_owner] = i_s_rdata;
                    end
                    if (w_owner_req) begin
                        w_m_ready_next[r_owner] = 1'b1;
                    end
                    w_s_request_next = 1'b0;
                    w_state_next     = RELEASE;
                end
            end

            RELEASE: begin
                // Slave request is low here, which lets the slave clear its
                // latency counter before the next grant.
                if (!w_owner_req || !r_m_ready[r_owner]) begin
                    w_m_ready_next = 2'b00;
                    w_state_next   = IDLE;
                end
            end

            default: begin
                w_m_ready_next   = 2'b00;
                w_s_request_next = 1'b0;
                w_state_next     = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight slave transaction.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_owner      <= MASTER0;
            r_last_grant <= MASTER1;
            r_s_request  <= 1'b0;
            r_s_rw       <= 1'b0;
            r_s_address  <= '0;
            r_s_wdata    <= '0;
            r_m_rdata    <= '0;
            r_m_ready    <= 2'b00;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_grant_next;
            r_s_request  <= w_s_request_next;
            r_s_rw       <= w_s_rw_next;
            r_s_address  <= w_s_address_next;
            r_s_wdata    <= w_s_wdata_next;
            r_m_rdata    <= w_m_rdata_next;
            r_m_ready    <= w_m_ready_next;
        end
    end

    assign o_s_request = r_s_request;
    assign o_s_rw      = r_s_rw;
    assign o_s_address = r_s_address;
    assign o_s_wdata   = r_s_wdata;
    assign o_m0_rdata  = r_m_rdata[0];
    assign o_m1_rdata  = r_m_rdata[1];
    assign o_m0_ready  = r_m_ready[0];
    assign o_m1_ready  = r_m_ready[1];

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Self-checking bench for bus_request_arbiter with a BRAM-style slave model.
module tb_bus_request_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        req;
    logic [1:0]        rw;
    logic [1:0][31:0]  addr;
    logic [1:0][31:0]  wdata;
    wire  [1:0][31:0]  rdata;
    wire  [1:0]        rdy;
    wire               s_req;
    wire               s_rw;
    wire  [31:0]       s_addr;
    wire  [31:0]       s_wdata;
    logic [31:0]       s_rdata = 32'h0;
    logic              s_ready = 1'b0;

    int nvec = 0;
    int nfail = 0;
    int lat = 3;
    bit init_mem = 1'b0;
    bit mon_en = 1'b0;
    int done_cnt [2];
    logic [31:0] sb_mem [64];

    bus_request_arbiter #(.WIDTH(32)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_m0_request (req[0]),
        .i_m0_rw      (rw[0]),
        .i_m0_address (addr[0]),
        .i_m0_wdata   (wdata[0]),
        .o_m0_rdata   (rdata[0]),
        .o_m0_ready   (rdy[0]),
        .i_m1_request (req[1]),
        .i_m1_rw      (rw[1]),
        .i_m1_address (addr[1]),
        .i_m1_wdata   (wdata[1]),
        .o_m1_rdata   (rdata[1]),
        .o_m1_ready   (rdy[1]),
        .o_s_request  (s_req),
        .o_s_rw       (s_rw),
        .o_s_address  (s_addr),
        .o_s_wdata    (s_wdata),
        .i_s_rdata    (s_rdata),
        .i_s_ready    (s_ready)
    );

    function automatic logic [31:0] init_val(int i);
        logic [31:0] iv;
        iv = 32'(i);
        return (i == 4) ? 32'hDEADBEEF : (32'h5A5A0000 ^ (iv * 32'h01010203));
    endfunction

    // Slave: latency counter runs while request is high, one-cycle ready pulse.
    logic [31:0] smem [64];
    int scnt = 0;
    always @(posedge clk) begin
        if (init_mem)
            for (int i = 0; i < 64; i++) smem[i] <= init_val(i);
        if (!s_req) begin
            scnt    <= 0;
            s_ready <= 1'b0;
        end else begin
            scnt    <= scnt + 1;
            s_ready <= (scnt == lat);
            if (scnt == lat) begin
                if (s_rw) smem[s_addr[7:2]] <= s_wdata;
                else      s_rdata <= smem[s_addr[7:2]];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave-side invariants: exclusive readies, frozen payload, >=2 idle cycles between requests.
    int lowrun = 100;
    logic prev_req = 1'b0;
    logic [64:0] cap = '0;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("ready_mutex", 32'(rdy != 2'b11), 1);
            if (s_req) begin
                if (!prev_req) begin
                    check("req_gap", 32'(lowrun >= 2), 1);
                    cap = {s_rw, s_addr, s_wdata};
                end else begin
                    check("s_stable", 32'({s_rw, s_addr, s_wdata} == cap), 1);
                end
                lowrun = 0;
            end else begin
                lowrun++;
            end
        end
        prev_req = s_req;
    end

    // One held-request transaction from master m; hold = extra cycles kept high after ready.
    task automatic txn(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] rd, output int lt);
        int n = 0;
        rw[m] = w; addr[m] = a; wdata[m] = d; req[m] = 1'b1;
        while (!rdy[m] && n < 100) begin
            tick();
            n++;
        end
        lt = n;
        rd = rdata[m];
        check($sformatf("m%0d_ready_seen", m), 32'(rdy[m]), 1);
        if (rdy[m]) done_cnt[m]++;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("held_ready", 32'(rdy[m]), 1);
            check("held_no_grant", 32'(s_req), 0);
        end
        req[m] = 1'b0;
        tick();
        check("ready_drop", 32'(rdy[m]), 0);
    endtask

    // Random traffic from one master, scored against a flat memory model.
    task automatic rand_master(input int m, input int cnt);
        int o = 1 - m;
        for (int k = 0; k < cnt; k++) begin
            int gap = $urandom_range(0, 3);
            int idx = $urandom_range(0, 63);
            logic w = 1'($urandom_range(0, 1));
            logic [31:0] d = $urandom;
            logic [31:0] rd;
            int lt, snap;
            for (int g = 0; g < gap; g++) tick();
            snap = done_cnt[o];
            txn(m, w, {24'h0, 6'(idx), 2'b00}, d, $urandom_range(0, 3), rd, lt);
            if (w) sb_mem[idx] = d;
            else   check($sformatf("rand_rdata_m%0d", m), rd, sb_mem[idx]);
            check("rr_fair", 32'((done_cnt[o] - snap) <= 1), 1);
        end
    endtask

    int order [$];
    task automatic rr_master(input int m);
        logic [31:0] rd;
        int lt;
        for (int k = 0; k < 2; k++) begin
            txn(m, 1'b0, 32'h10, 32'h0, 0, rd, lt);
            order.push_back(m);
        end
    endtask

    typedef struct {
        int          m;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl [8];

    initial begin
        logic [31:0] rd;
        int lt, n;

        tbl[0] = '{0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        tbl[1] = '{1, 1'b1, 32'h20, 32'h12345678, 32'h0};
        tbl[2] = '{1, 1'b0, 32'h20, 32'h0,        32'h12345678};
        tbl[3] = '{0, 1'b1, 32'h24, 32'hCAFEF00D, 32'hDEADBEEF};
        tbl[4] = '{0, 1'b0, 32'h24, 32'h0,        32'hCAFEF00D};
        tbl[5] = '{1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        tbl[6] = '{1, 1'b1, 32'h10, 32'h0,        32'hDEADBEEF};
        tbl[7] = '{0, 1'b0, 32'h10, 32'h0,        32'h0};

        req = '0; rw = '0; addr = '0; wdata = '0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        init_mem = 1'b1;
        tick();
        init_mem = 1'b0;

        // Reset values
        check("rst_s_request", 32'(s_req), 0);
        check("rst_s_rw", 32'(s_rw), 0);
        check("rst_s_address", s_addr, 0);
        check("rst_s_wdata", s_wdata, 0);
        check("rst_ready", 32'(rdy), 0);
        check("rst_m0_rdata", rdata[0], 0);
        check("rst_m1_rdata", rdata[1], 0);
        tick();
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Solo transactions, each from idle: latency L+3 = 6
        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].m, tbl[i].w, tbl[i].a, tbl[i].d, 0, rd, lt);
            check($sformatf("tbl%0d_latency", i), 32'(lt), 6);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            if (i == 0) check("tbl0_m1_rdata_idle", rdata[1], 0);
        end

        // Contention right after reset: m0 first, then strict alternation
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        order.delete();
        fork
            rr_master(0);
            rr_master(1);
        join
        check("rr_count", 32'(order.size()), 4);
        for (int i = 0; i < order.size(); i++)
            check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));

        // Held ready: m0 holds 4 cycles, m1 waits behind it
        fork
            begin
                txn(0, 1'b0, 32'h24, 32'h0, 4, rd, lt);
                check("held_m0_rdata", rd, 32'hCAFEF00D);
            end
            begin
                logic [31:0] rd1;
                int lt1;
                tick();
                txn(1, 1'b0, 32'h20, 32'h0, 0, rd1, lt1);
                check("held_m1_rdata", rd1, 32'h12345678);
            end
        join

        // Early drop during BUSY: no ready, back to IDLE two edges after slave ready
        rw[0] = 1'b0; addr[0] = 32'h20; req[0] = 1'b1;
        tick(); tick();
        req[0] = 1'b0;
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            check("early_no_ready", 32'(rdy[0]), 0);
            n++;
        end
        check("early_sready_seen", 32'(s_ready), 1);
        tick();
        check("early_s_req_low", 32'(s_req), 0);
        check("early_no_ready_done", 32'(rdy[0]), 0);
        tick();
        rw[1] = 1'b0; addr[1] = 32'h24; req[1] = 1'b1;
        tick();
        check("early_regrant", 32'(s_req), 1);
        n = 0;
        while (!rdy[1] && n < 50) begin
            tick();
            n++;
        end
        check("early_m1_rdata", rdata[1], 32'hCAFEF00D);
        req[1] = 1'b0;
        tick();

        // Async reset while the slave transaction is pending
        rw[0] = 1'b0; addr[0] = 32'h10; req[0] = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("rstbusy_s_request", 32'(s_req), 0);
        check("rstbusy_s_address", s_addr, 0);
        check("rstbusy_ready", 32'(rdy), 0);
        check("rstbusy_m1_rdata", rdata[1], 0);
        req[0] = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        txn(1, 1'b0, 32'h24, 32'h0, 0, rd, lt);
        check("rstbusy_after_rdata", rd, 32'hCAFEF00D);
        check("rstbusy_after_latency", 32'(lt), 6);

        // Randomized concurrent traffic against the memory model
        init_mem = 1'b1;
        tick();
        init_mem = 1'b0;
        for (int i = 0; i < 64; i++) sb_mem[i] = init_val(i);
        lat = $urandom_range(0, 4);
        fork
            rand_master(0, 40);
            rand_master(1, 40);
        join

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_request_arbiter.md
# bus_request_arbiter

Two-master, round-robin arbiter feeding one request/ready memory port (e.g. one port of the dual-port latency BRAM). It accepts held-request transactions from two masters, latches the winner's payload, drives it to the slave until `i_s_ready`, and returns data/ready to the owner using the same held-request protocol the slave exposes. This keeps the slave protocol transparent to both masters.

## Interface
Parameters:
- `WIDTH`, 32: data width of wdata/rdata on all ports.

Ports:
- `i_clock`  in  1  single clock; all state on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_m0_request`  in  1  master 0 transaction request; held until `o_m0_ready`, dropped afterwards.
- `i_m0_rw`  in  1  0 = read, 1 = write.
- `i_m0_address`  in  32  byte address, passed unmodified.
- `i_m0_wdata`  in  WIDTH  write data.
- `o_m0_rdata`  out  WIDTH  read data; valid while `o_m0_ready` is high after a read.
- `o_m0_ready`  out  1  completion; high from completion until master drops request.
- `i_m1_*` / `o_m1_*`: identical set for master 1.
- `o_s_request`  out  1  slave request, registered.
- `o_s_rw`  out  1  latched rw of owner.
- `o_s_address`  out  32  latched address of owner.
- `o_s_wdata`  out  WIDTH  latched wdata of owner.
- `i_s_rdata`  in  WIDTH  slave read data, valid when `i_s_ready`.
- `i_s_ready`  in  1  slave completion.

## Operation
- Registered state `owner` (0/1), `last_grant` (0/1).
- FSM states: IDLE, BUSY, RELEASE.
- IDLE: if exactly one master requests, grant it. If both request, grant the master not equal to `last_grant`. On grant: latch rw/address/wdata into `o_s_*`, assert `o_s_request`, set `owner`/`last_grant`, go to BUSY.
- BUSY: hold `o_s_*` stable. When `i_s_ready` is sampled high:
  - on read, copy `i_s_rdata` into owner's `o_mX_rdata`; on write, rdata is unchanged;
  - set owner's `o_mX_ready`, clear `o_s_request`, go to RELEASE.
- RELEASE: `o_s_request` stays low, so the slave latency counter clears. Owner's `o_mX_ready` stays high while the owner's request is high. When the owner's request is sampled low, clear `o_mX_ready` and go to IDLE.
- Non-owner requests wait unchanged; its ready stays 0.
- A master dropping its request in BUSY (protocol violation): the transaction still completes to the slave; ready is not asserted; RELEASE exits immediately.
- Reset (async, any state): state IDLE; `last_grant`=1, so m0 wins first contention. `o_s_request`, `o_m0_ready`, `o_m1_ready`=0; `o_s_rw`=0; `o_s_address`, `o_s_wdata`, `o_m0_rdata`, `o_m1_rdata`=0. An in-flight slave transaction is abandoned. The slave sees the request drop on the first post-reset clock edge.

## Timing
- Grant latency: request sampled in IDLE at edge N → `o_s_request` high after edge N.
- Completion: `i_s_ready` sampled at edge E → `o_mX_ready`/`o_mX_rdata` valid and `o_s_request` low after E.
- Minimum gap with `o_s_request` low between slave transactions is 2 cycles: RELEASE plus IDLE.
- With a slave of latency L (ready first seen at edge N+1+L+1), master-observed latency from request to ready is L+3 cycles. The next grant comes at the earliest 2 edges after completion, if the owner drops request immediately.
- `o_s_*` never changes while `o_s_request` is high.
- Ready outputs are mutually exclusive.

## Structure
- Package `bus_request_arbiter_pkg`: `state_t` enum (IDLE, BUSY, RELEASE); `master_id_t` (1-bit).
- Sub-module `rr_pick2`: combinational round-robin picker. Inputs are two requests and `last_grant`; outputs are `grant_valid` and `grant_id`. The arbiter instantiates it once.

## Test plan
- Single read: BRAM slave LATENCY=3, mem[0x10>>2]=0xDEADBEEF; m0 read 0x10 → `o_m0_ready` after 6 cycles, `o_m0_rdata`=0xDEADBEEF; m1 outputs stay 0.
- Write then read: m1 writes 0x20 ← 0x12345678, drops request, then reads 0x20 → rdata 0x12345678. `o_s_request` is low for ≥2 cycles between the two transactions.
- Contention: m0 and m1 request the same cycle after reset → m0 served first, then m1. Repeat both continuously → grants alternate m0, m1, m0, m1.
- Held ready: m0 keeps request high 4 cycles after completion → `o_m0_ready` stays high 4 cycles; m1 is not granted until m0 drops.
- Reset mid-BUSY: assert `i_reset_n`=0 with slave pending → all outputs 0 immediately (async). After release, a new m1 read completes with correct data.
- Early drop: m0 drops request during BUSY → slave transaction completes, `o_m0_ready` never asserts, FSM returns to IDLE within 2 cycles of `i_s_ready`.
